// File: rtl/apu_dma_pkg.sv
// rtl/apu_dma_pkg.sv - shared state type and defaults for the APU DMA responder
package apu_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_DUMMY,
        ST_ALIGN,
        ST_OAM_GET,
        ST_OAM_PUT,
        ST_DMC_GET
    } dma_state_t;

    localparam logic [4:0]  OAM_TRIG_OFS      = 5'h14;
    localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;
    localparam int          DMC_LOCKOUT_DEF   = 2;

endpackage

// File: rtl/apu_dma.sv
// rtl/apu_dma.sv - DMC sample-fetch and OAM DMA responder: halts the CPU, owns the bus, returns it
module apu_dma
    import apu_dma_pkg::*;
#(
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF,
    parameter int          DMC_LOCKOUT   = DMC_LOCKOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        apu_cycle,
    input  logic [4:0]  apu_addr,
    input  logic        apu_wr,
    input  logic [7:0]  data_in,
    input  logic        cpu_rw,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic [15:0] dma_address,
    output logic        dma_active,
    output logic        bus_own,
    output logic [15:0] bus_addr,
    output logic        bus_wr,
    output logic [7:0]  bus_dout
);

    dma_state_t state, state_n;
    dma_state_t first_get, realign;
    logic [7:0] page, idx, idx_n;
    logic       oam_pend, oam_pend_n;
    logic [3:0] lockout;
    logic       dmc_trig, oam_trig;

    // A DMC read already on the bus must not count as a fresh request.
    assign dmc_trig = dma_req && (lockout == 4'd0) && (state != ST_DMC_GET);
    assign oam_trig = apu_wr && (apu_addr == OAM_TRIG_OFS) && !oam_pend;

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        oam_pend_n = oam_pend | oam_trig;
        first_get  = dmc_trig ? ST_DMC_GET : ST_OAM_GET;
        // apu_cycle alternates, so a put cycle now means the next clk is a get.
        realign    = apu_cycle ? ST_ALIGN : first_get;

        case (state)
            ST_IDLE: begin
                if (dmc_trig || oam_pend || oam_trig)
                    state_n = ST_HALT;
            end
            ST_HALT: begin
                if (!dmc_trig && !oam_pend)
                    state_n = ST_IDLE;
                else if (cpu_rw)
                    state_n = oam_pend ? realign : ST_DUMMY;
            end
            ST_DUMMY, ST_ALIGN: begin
                if (!dmc_trig && !oam_pend)
                    state_n = ST_IDLE;
                else
                    state_n = realign;
            end
            ST_DMC_GET: begin
                state_n = oam_pend ? realign : ST_IDLE;
            end
            ST_OAM_GET: begin
                state_n = ST_OAM_PUT;
            end
            ST_OAM_PUT: begin
                idx_n = idx + 8'd1;
                if (idx == 8'hFF) begin
                    oam_pend_n = 1'b0;
                    state_n    = dmc_trig ? realign : ST_IDLE;
                end else begin
                    state_n = realign;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= 8'd0;
            page       <= 8'd0;
            oam_pend   <= 1'b0;
            lockout    <= 4'd0;
            cpu_rdy    <= 1'b1;
            dma_active <= 1'b0;
            bus_own    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_addr   <= 16'd0;
            bus_dout   <= 8'd0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            oam_pend <= oam_pend_n;
            if (oam_trig)
                page <= data_in;

            if (state == ST_DMC_GET)
                lockout <= 4'(DMC_LOCKOUT);
            else if (lockout != 4'd0)
                lockout <= lockout - 4'd1;

            // Outputs are decoded from the next state so they line up with the state's own clk.
            cpu_rdy    <= (state_n == ST_IDLE);
            dma_active <= (state_n == ST_DMC_GET);
            bus_own    <= (state_n inside {ST_OAM_GET, ST_OAM_PUT, ST_DMC_GET});
            bus_wr     <= (state_n == ST_OAM_PUT);
            case (state_n)
                ST_DMC_GET: bus_addr <= dma_address;
                ST_OAM_GET: bus_addr <= {page, idx_n};
                ST_OAM_PUT: bus_addr <= OAM_DATA_ADDR;
                default:    bus_addr <= 16'd0;
            endcase

            if (state == ST_OAM_GET)
                bus_dout <= data_in;
        end
    end

endmodule

// File: tb/tb_apu_dma.sv
// tb/tb_apu_dma.sv - self-checking bench for apu_dma: vector table, random scenarios, corner sequences
module tb_apu_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        apu_cycle = 1'b0;
    logic [4:0]  apu_addr;
    logic        apu_wr;
    logic [7:0]  data_in;
    logic        cpu_rw;
    logic        cpu_rdy;
    logic        dma_req;
    logic [15:0] dma_address;
    logic        dma_active;
    logic        bus_own;
    logic [15:0] bus_addr;
    logic        bus_wr;
    logic [7:0]  bus_dout;
    logic [7:0]  cpu_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic        act;
        logic [15:0] addr;
        logic [7:0]  dat;
    } op_t;

    typedef struct {
        string       name;
        bit          oam;
        logic [7:0]  page;
        bit          dmc;
        int          steal_at;
        bit          phase;
        int          stall;
        logic [15:0] daddr;
        int          cycles;
    } vec_t;

    op_t  exp_q[$];
    vec_t tbl[$];

    apu_dma dut (
        .clk         (clk),
        .rst         (rst),
        .apu_cycle   (apu_cycle),
        .apu_addr    (apu_addr),
        .apu_wr      (apu_wr),
        .data_in     (data_in),
        .cpu_rw      (cpu_rw),
        .cpu_rdy     (cpu_rdy),
        .dma_req     (dma_req),
        .dma_address (dma_address),
        .dma_active  (dma_active),
        .bus_own     (bus_own),
        .bus_addr    (bus_addr),
        .bus_wr      (bus_wr),
        .bus_dout    (bus_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) #1 apu_cycle = ~apu_cycle;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Memory answers any DMA read combinationally; otherwise the CPU drives the bus.
    assign data_in = (bus_own && !bus_wr) ? mem_byte(bus_addr) : cpu_data;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Halt cycle, plus a put to realign when halted on a get, plus 256 get/put pairs;
    // a DMC read on its own needs halt, dummy, optional realign, get.
    function automatic int model_cycles(input bit oam, input bit steal, input bit halt_phase, input int stall);
        int c;
        if (oam)
            c = 1 + (halt_phase ? 1 : 0) + 512 + (steal ? 2 : 0);
        else
            c = halt_phase ? 3 : 4;
        return c + stall;
    endfunction

    function automatic vec_t mk(input string name, input bit oam, input logic [7:0] page, input bit dmc,
                                input int steal_at, input bit phase, input int stall,
                                input logic [15:0] daddr, input int cycles);
        vec_t v;
        v.name = name; v.oam = oam; v.page = page; v.dmc = dmc; v.steal_at = steal_at;
        v.phase = phase; v.stall = stall; v.daddr = daddr; v.cycles = cycles;
        return v;
    endfunction

    task automatic build_ops(input vec_t v);
        op_t o;
        exp_q.delete();
        if (v.oam) begin
            for (int i = 0; i < 256; i++) begin
                if (v.dmc && i == v.steal_at) begin
                    o.wr = 1'b0; o.act = 1'b1; o.addr = v.daddr; o.dat = 8'h00;
                    exp_q.push_back(o);
                end
                o.wr = 1'b0; o.act = 1'b0; o.addr = {v.page, 8'(i)}; o.dat = 8'h00;
                exp_q.push_back(o);
                o.wr = 1'b1; o.act = 1'b0; o.addr = 16'h2004; o.dat = mem_byte({v.page, 8'(i)});
                exp_q.push_back(o);
            end
        end else if (v.dmc) begin
            o.wr = 1'b0; o.act = 1'b1; o.addr = v.daddr; o.dat = 8'h00;
            exp_q.push_back(o);
        end
    endtask

    // v.phase is apu_cycle on the first clk after the trigger.
    task automatic run_vec(input vec_t v);
        int   low;
        bit   done;
        bit   stall_bus;
        op_t  e;
        logic [7:0] pre_idx;
        build_ops(v);
        low = 0; done = 0; stall_bus = 0;
        pre_idx = 8'(v.steal_at - 1);
        repeat (3) @(negedge clk);
        while (apu_cycle == v.phase) @(negedge clk);
        dma_address = v.daddr;
        if (v.oam) begin
            apu_wr = 1'b1; apu_addr = 5'h14; cpu_data = v.page;
        end else if (v.dmc) begin
            dma_req = 1'b1;
        end
        for (int i = 1; i <= 3000 && !done; i++) begin
            @(negedge clk);
            apu_wr   = 1'b0;
            cpu_data = 8'h00;
            cpu_rw   = (i <= v.stall) ? 1'b0 : 1'b1;
            if (cpu_rdy) begin
                done = 1;
            end else begin
                low++;
                if (bus_own && i <= v.stall)
                    stall_bus = 1;
                if (bus_own || dma_active || bus_wr) begin
                    if (exp_q.size() == 0) begin
                        check({v.name, " extra_op"}, {bus_wr, dma_active, bus_addr}, 32'hFFFFFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check({v.name, " op"}, {bus_wr, dma_active, bus_addr, (bus_wr ? bus_dout : 8'h00)},
                              {e.wr, e.act, e.addr, (e.wr ? e.dat : 8'h00)});
                    end
                end
                if (dma_active)
                    dma_req = 1'b0;
                if (v.oam && v.dmc && bus_own && !bus_wr && !dma_active && bus_addr == {v.page, pre_idx})
                    dma_req = 1'b1;
            end
        end
        check({v.name, " cycles"}, low, v.cycles);
        check({v.name, " ops_left"}, exp_q.size(), 0);
        check({v.name, " stall_bus"}, stall_bus, 0);
        cpu_rw  = 1'b1;
        dma_req = 1'b0;
    endtask

    initial begin
        vec_t v;
        bit   got;
        bit   saw;
        bit   ph;
        int   st;

        rst = 1'b1; apu_addr = 5'h00; apu_wr = 1'b0; cpu_rw = 1'b1;
        dma_req = 1'b0; dma_address = 16'h0000; cpu_data = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_state", {cpu_rdy, dma_active, bus_own, bus_wr, bus_addr, bus_dout}, {1'b1, 3'b000, 24'h0});
        rst = 1'b0;

        tbl.push_back(mk("dmc_put",     0, 8'h00, 1, 0,    0, 0, 16'hC000, 4));
        tbl.push_back(mk("dmc_get",     0, 8'h00, 1, 0,    1, 0, 16'hC001, 3));
        tbl.push_back(mk("oam_put",     1, 8'h02, 0, 0,    0, 0, 16'h0000, 513));
        tbl.push_back(mk("oam_get",     1, 8'h02, 0, 0,    1, 0, 16'h0000, 514));
        tbl.push_back(mk("oam_wrstall", 1, 8'h03, 0, 0,    0, 2, 16'h0000, 515));
        tbl.push_back(mk("oam_steal",   1, 8'h02, 1, 8'h40, 0, 0, 16'hC123, 515));
        tbl.push_back(mk("dmc_wrstall", 0, 8'h00, 1, 0,    1, 2, 16'hD000, 5));
        foreach (tbl[k]) run_vec(tbl[k]);

        for (int r = 0; r < 6; r++) begin
            v.name  = $sformatf("rand%0d", r);
            v.oam   = $urandom_range(0, 1);
            v.dmc   = v.oam ? $urandom_range(0, 1) : 1'b1;
            v.steal_at = $urandom_range(1, 255);
            v.page  = 8'($urandom);
            v.daddr = 16'($urandom) | 16'h8000;
            ph      = $urandom_range(0, 1);
            st      = $urandom_range(0, 3);
            v.phase = ph;
            v.stall = st;
            v.cycles = model_cycles(v.oam, v.oam && v.dmc, ph ^ st[0], st);
            run_vec(v);
        end

        // DMC requester keeps dma_req high briefly after its read: lockout must hide it.
        repeat (3) @(negedge clk);
        dma_address = 16'hC000; dma_req = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (dma_active) got = 1;
        end
        check("lock_service", got, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("lock_idle", {cpu_rdy, bus_own, dma_active}, 3'b100);
        end
        dma_req = 1'b0;

        // Abandon a DMC fetch in the realign slot.
        repeat (4) @(negedge clk);
        while (apu_cycle != 1'b1) @(negedge clk);
        dma_address = 16'hC040; dma_req = 1'b1;
        saw = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (dma_active) saw = 1;
            check("abort_halted", cpu_rdy, 0);
            if (i == 3) dma_req = 1'b0;
        end
        @(negedge clk);
        check("abort_release", {cpu_rdy, bus_own}, 2'b10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dma_active) saw = 1;
        end
        check("abort_no_fetch", saw, 0);

        // Async reset in the middle of an OAM transfer, then a fresh transfer from idx 0.
        repeat (3) @(negedge clk);
        apu_wr = 1'b1; apu_addr = 5'h14; cpu_data = 8'h05;
        @(negedge clk);
        apu_wr = 1'b0; cpu_data = 8'h00;
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (bus_own && !bus_wr && bus_addr == 16'h0580) got = 1;
        end
        check("rst_reach_idx80", got, 1);
        #2 rst = 1'b1;
        #1 check("rst_async_outputs", {cpu_rdy, dma_active, bus_own, bus_wr, bus_addr, bus_dout}, {1'b1, 3'b000, 24'h0});
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk("oam_after_rst", 1, 8'h05, 0, 0, 0, 0, 16'h0000, 513));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
